// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: round-robin arbitration of NUM_SRC writeback requesters onto one
// registered regfile write port, plus a per-GPR pending-write scoreboard for RAW/WAW stalls.

package rv32;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_COUNT = 32;

    typedef logic [$clog2(REG_COUNT)-1:0] gpr_addr_t;
    typedef logic [XLEN-1:0]              word;
endpackage

module regfile_wb_sched #(
    parameter int unsigned NUM_SRC = 3
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic [NUM_SRC-1:0]              wb_valid,
    output logic [NUM_SRC-1:0]              wb_ready,
    input  rv32::gpr_addr_t [NUM_SRC-1:0]   wb_addr,
    input  rv32::word [NUM_SRC-1:0]         wb_data,

    output logic                            dest_en,
    output rv32::gpr_addr_t                 dest_addr,
    output rv32::word                       dest_data,

    input  logic                            issue_en,
    input  rv32::gpr_addr_t                 issue_addr,
    output logic                            issue_ok,

    input  rv32::gpr_addr_t                 rs1_addr,
    output logic                            rs1_busy,
    input  rv32::gpr_addr_t                 rs2_addr,
    output logic                            rs2_busy
);

    localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    typedef logic [IdxW-1:0] idx_t;
    localparam idx_t LastRst = idx_t'(NUM_SRC - 1);

    idx_t                        last_q;
    idx_t                        grant_idx;
    logic                        grant_any;
    rv32::gpr_addr_t             sel_addr;
    rv32::word                   sel_data;
    logic                        keep_write;
    logic [rv32::REG_COUNT-1:0]  busy_q;
    logic [rv32::REG_COUNT-1:0]  busy_d;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        idx_t cand;
        cand      = '0;
        grant_any = 1'b0;
        grant_idx = last_q;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = idx_t'((32'(last_q) + k) % NUM_SRC);
            if (!grant_any && wb_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (rst) begin
            grant_any = 1'b0;
        end
    end

    always_comb begin
        wb_ready = '0;
        if (grant_any) begin
            wb_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_addr   = wb_addr[grant_idx];
    assign sel_data   = wb_data[grant_idx];
    // x0 writes still consume the grant but never reach the regfile.
    assign keep_write = grant_any && (sel_addr != '0);

    always_comb begin
        busy_d = busy_q;
        if (dest_en && dest_addr != '0) begin
            busy_d[dest_addr] = 1'b0;
        end
        if (issue_en && issue_addr != '0) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            last_q    <= LastRst;
            dest_en   <= 1'b0;
            dest_addr <= '0;
            dest_data <= '0;
        end else begin
            busy_q  <= busy_d;
            dest_en <= keep_write;
            if (keep_write) begin
                dest_addr <= sel_addr;
                dest_data <= sel_data;
            end
            if (grant_any) begin
                last_q <= grant_idx;
            end
        end
    end

    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];
    assign issue_ok = ~busy_q[issue_addr];

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(wb_ready));
    a_ready_valid:  assert property (@(posedge clk) disable iff (rst) (wb_ready & ~wb_valid) == '0);

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched: an abstract model predicts grants, scoreboard bits
// and queued regfile writes; a separate monitor checks the dest port against the queue.

module tb_regfile_wb_sched;
    localparam int NS = 3;
    localparam int IW = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NS-1:0]              wb_valid;
    logic [NS-1:0]              wb_ready;
    rv32::gpr_addr_t [NS-1:0]   wb_addr;
    rv32::word [NS-1:0]         wb_data;
    logic                       dest_en;
    rv32::gpr_addr_t            dest_addr;
    rv32::word                  dest_data;
    logic                       issue_en;
    rv32::gpr_addr_t            issue_addr;
    logic                       issue_ok;
    rv32::gpr_addr_t            rs1_addr;
    logic                       rs1_busy;
    rv32::gpr_addr_t            rs2_addr;
    logic                       rs2_busy;

    regfile_wb_sched #(.NUM_SRC(NS)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .dest_en    (dest_en),
        .dest_addr  (dest_addr),
        .dest_data  (dest_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .issue_ok   (issue_ok),
        .rs1_addr   (rs1_addr),
        .rs1_busy   (rs1_busy),
        .rs2_addr   (rs2_addr),
        .rs2_busy   (rs2_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        rv32::gpr_addr_t addr;
        rv32::word       data;
    } exp_t;

    exp_t      exp_q[$];
    int        n_tests = 0;
    int        n_fail  = 0;
    int        cyc     = 0;
    bit        mon_on  = 1'b0;

    // Reference model state
    bit [31:0]       m_busy;
    int              m_last;
    bit              m_dv;
    rv32::gpr_addr_t m_da;
    int              wait_cnt[NS];

    // Random requesters hold their request until accepted
    bit              rq_v[NS];
    rv32::gpr_addr_t rq_a[NS];
    rv32::word       rq_d[NS];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    a_issue_protocol: assert property (@(posedge clk) disable iff (rst) issue_en |-> issue_ok);

    // Monitor: every dest_en must match the next queued write, in the expected cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (dest_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("dest_en_unexpected", 32'(dest_en), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dest_cycle", 32'(cyc), 32'(e.cyc));
                    chk("dest_addr", 32'(dest_addr), 32'(e.addr));
                    chk("dest_data", dest_data, e.data);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                chk("dest_en_missing", 32'(dest_en), 32'd1);
            end
        end
    end

    function automatic void model_reset();
        m_busy = '0;
        m_last = NS - 1;
        m_dv   = 1'b0;
        m_da   = '0;
        for (int i = 0; i < NS; i++) wait_cnt[i] = 0;
    endfunction

    // One clock cycle: inputs already driven; check at negedge, then advance the model.
    task automatic step(input bit do_rst, output int g);
        logic [NS-1:0] exp_rdy;
        int            c;
        exp_t          e;
        rst = do_rst;
        @(negedge clk);
        g = -1;
        if (!do_rst) begin
            for (int k = 1; k <= NS; k++) begin
                int s = (m_last + k) % NS;
                if (g < 0 && wb_valid[IW'(s)]) g = s;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[IW'(g)] = 1'b1;
        chk("wb_ready", 32'(wb_ready), 32'(exp_rdy));
        chk("rs1_busy", 32'(rs1_busy), 32'(m_busy[rs1_addr]));
        chk("rs2_busy", 32'(rs2_busy), 32'(m_busy[rs2_addr]));
        chk("issue_ok", 32'(issue_ok), 32'(!m_busy[issue_addr]));
        for (int i = 0; i < NS; i++) begin
            if (do_rst || !wb_valid[IW'(i)]) begin
                wait_cnt[i] = 0;
            end else if (wb_ready[IW'(i)] === 1'b1) begin
                chk("starve_bound", 32'(wait_cnt[i] < NS), 32'd1);
                wait_cnt[i] = 0;
            end else begin
                wait_cnt[i]++;
                if (wait_cnt[i] == NS) chk("starve_wait", 32'(wb_ready[IW'(i)]), 32'd1);
            end
        end
        c = cyc;
        @(posedge clk);
        if (do_rst) begin
            model_reset();
        end else begin
            if (m_dv) m_busy[m_da] = 1'b0;
            if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
            m_dv = 1'b0;
            if (g >= 0) begin
                m_last = g;
                if (wb_addr[IW'(g)] != 0) begin
                    e.cyc  = c + 1;
                    e.addr = wb_addr[IW'(g)];
                    e.data = wb_data[IW'(g)];
                    exp_q.push_back(e);
                    m_dv = 1'b1;
                    m_da = wb_addr[IW'(g)];
                end
            end
        end
        #1;
    endtask

    function automatic rv32::gpr_addr_t pick_addr();
        int r;
        int st;
        int a;
        r = $urandom_range(0, 9);
        if (r < 2) return '0;
        if (r < 6) begin
            st = $urandom_range(0, 30);
            for (int k = 0; k < 31; k++) begin
                a = 1 + (st + k) % 31;
                if (m_busy[a]) return rv32::gpr_addr_t'(a);
            end
        end
        return rv32::gpr_addr_t'($urandom_range(1, 31));
    endfunction

    initial begin
        int g;
        bit do_rst;
        int a;
        wb_valid   = '0;
        wb_addr    = '0;
        wb_data    = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
        rs1_addr   = '0;
        rs2_addr   = '0;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        mon_on = 1'b1;

        // Reset state, and no grant while reset is held
        chk("rst_dest_en", 32'(dest_en), 32'd0);
        chk("rst_dest_addr", 32'(dest_addr), 32'd0);
        chk("rst_dest_data", dest_data, 32'd0);
        wb_valid = 3'b111;
        wb_addr  = {5'd3, 5'd2, 5'd1};
        step(1'b1, g);
        wb_valid = '0;

        // Single write of x7 by source 1
        issue_en = 1'b1; issue_addr = 5'd7; rs1_addr = 5'd7;
        step(1'b0, g);
        issue_en = 1'b0;
        wb_valid = 3'b010; wb_addr[1] = 5'd7; wb_data[1] = 32'hDEADBEEF;
        step(1'b0, g);
        wb_valid = '0;
        repeat (2) step(1'b0, g);

        // Round-robin from reset with all sources valid
        step(1'b1, g);
        wb_valid = 3'b111;
        for (int i = 0; i < NS; i++) begin
            wb_addr[i] = rv32::gpr_addr_t'(i + 1);
            wb_data[i] = $urandom();
        end
        for (int n = 0; n < 6; n++) begin
            step(1'b0, g);
            if (g >= 0) wb_data[IW'(g)] = $urandom();
        end
        wb_valid = '0;
        repeat (2) step(1'b0, g);

        // x0: issue and write are both ignored by the scoreboard
        issue_en = 1'b1; issue_addr = '0; rs1_addr = '0;
        step(1'b0, g);
        issue_en = 1'b0;
        wb_valid = 3'b100; wb_addr[2] = '0; wb_data[2] = 32'h1234_5678;
        step(1'b0, g);
        wb_valid = '0;
        repeat (2) step(1'b0, g);

        // Set/clear collision on x9: issue lands on the edge the write clears
        wb_valid = 3'b001; wb_addr[0] = 5'd9; wb_data[0] = 32'hA5A5_0009; rs2_addr = 5'd9;
        step(1'b0, g);
        wb_valid = '0; issue_en = 1'b1; issue_addr = 5'd9;
        step(1'b0, g);
        issue_en = 1'b0;
        step(1'b0, g);
        wb_valid = 3'b001; wb_data[0] = 32'h0000_0909;
        step(1'b0, g);
        wb_valid = '0;
        repeat (2) step(1'b0, g);

        // WAW stall on x12
        issue_en = 1'b1; issue_addr = 5'd12;
        step(1'b0, g);
        issue_en = 1'b0;
        repeat (3) step(1'b0, g);
        wb_valid = 3'b010; wb_addr[1] = 5'd12; wb_data[1] = 32'hC0DE_000C;
        step(1'b0, g);
        wb_valid = '0;
        repeat (2) step(1'b0, g);

        // Reset mid-operation: x5 busy and a write in the dest stage
        issue_en = 1'b1; issue_addr = 5'd5; rs1_addr = 5'd5;
        step(1'b0, g);
        issue_en = 1'b0;
        wb_valid = 3'b010; wb_addr[1] = 5'd3; wb_data[1] = 32'h5555_0003;
        step(1'b0, g);
        wb_valid = '0;
        step(1'b1, g);
        wb_valid = 3'b111;
        wb_addr  = {5'd0, 5'd0, 5'd4};
        step(1'b0, g);
        wb_valid = '0;
        repeat (2) step(1'b0, g);

        // Randomized traffic
        for (int i = 0; i < NS; i++) rq_v[i] = 1'b0;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NS; i++) begin
                if (!rq_v[i] && $urandom_range(0, 99) < 55) begin
                    rq_v[i] = 1'b1;
                    rq_a[i] = pick_addr();
                    rq_d[i] = $urandom();
                end
                wb_valid[i] = rq_v[i];
                wb_addr[i]  = rq_a[i];
                wb_data[i]  = rq_d[i];
            end
            do_rst = ($urandom_range(0, 199) == 0);
            a = $urandom_range(0, 31);
            issue_addr = rv32::gpr_addr_t'(a);
            issue_en   = !do_rst && !m_busy[a] && ($urandom_range(0, 2) == 0);
            rs1_addr   = rv32::gpr_addr_t'($urandom_range(0, 31));
            rs2_addr   = rv32::gpr_addr_t'($urandom_range(0, 31));
            step(do_rst, g);
            if (g >= 0) rq_v[g] = 1'b0;
        end
        wb_valid = '0;
        issue_en = 1'b0;
        repeat (3) step(1'b0, g);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
